match_timer_judge: RTL and testbench
====================================

Name: match_timer_judge

Overview:
- Upstream judge for the game-mode FSM; produces its gameOver input.
- Runs while ingameOn=1: counts down the round timer and the matched pairs reported by the tile-compare logic.
- Asserts gameOver on win (all pairs matched) or loss (timer expired) and holds it until userquit.
- Exports seconds left, pairs left and score for HEX/VGA display.

Parameters:
- CLKS_PER_SEC, 50000000, CLOCK_50 cycles per game second.
- GAME_SECONDS, 60, round length in seconds (1..127).
- NUM_PAIRS, 8, tile pairs on the board (1..31).
- SCORE_HIT, 10, points added per correct match.
- MAX_MISSES, 5, mismatch limit (used only with MISS_LIMIT_EN).

Ports:
- CLOCK_50  input  1  system clock.
- userquit  input  1  asynchronous active-high reset; also the player quit.
- ingameOn  input  1  high while the game-mode FSM is in-game.
- pair_valid  input  1  one-cycle pulse: a two-tile guess is complete.
- pair_match  input  1  qualifies pair_valid: 1 = match, 0 = mismatch.
- gameOver  output  1  registered, level; high in WON/LOST.
- win  output  1  registered; high only in WON.
- secs_left  output  7  remaining seconds.
- pairs_left  output  5  unmatched pairs.
- score  output  8  accumulated score.
- sec_tick  output  1  one-cycle pulse per elapsed game second while running.

Behaviour:
- Reset: userquit=1 asynchronously forces:
  - state IDLE, prescaler 0
  - secs_left=GAME_SECONDS, pairs_left=NUM_PAIRS, score=0, misses=0
  - gameOver=0, win=0, sec_tick=0
- States:
  - IDLE → RUN when ingameOn=1 (sampled at the clock edge). Counters are reloaded to reset values on entry.
  - RUN: prescaler counts 0..CLKS_PER_SEC-1 and wraps. On wrap, sec_tick=1 for that cycle and secs_left decrements.
  - RUN, pair_valid & pair_match: pairs_left decrements and score += SCORE_HIT, saturating at 255.
  - RUN, pair_valid & !pair_match: no score change; misses increments (feature only).
  - RUN → WON when a match brings pairs_left from 1 to 0.
  - RUN → LOST when a tick brings secs_left from 1 to 0.
  - Same-cycle last match and last tick: WON takes priority; secs_left still updates to 0.
  - RUN → IDLE if ingameOn drops without a game-over (abort). All counters reset, gameOver stays 0.
  - WON/LOST are terminal; ingameOn changes are ignored. Only userquit exits.
- Latency: gameOver and win rise on the same clock edge that updates the final counter value (one cycle after the qualifying pulse or wrap). The game-mode FSM then moves to endgame one edge later.
- In WON/LOST all counters freeze, sec_tick=0, and pair_valid is ignored.
- In IDLE, pair_valid is ignored.
- Counter bounds: pairs_left never underflows; pulses at 0 are impossible because the state leaves RUN first. secs_left never underflows.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: MISS_LIMIT_EN.
- Defined:
  - 3-bit misses counter, saturating at 7.
  - RUN → LOST on the mismatch that brings misses to MAX_MISSES.
  - A match takes priority over a same-cycle timer loss.
  - A mismatch-loss coinciding with a final tick yields LOST (same outcome).
- Undefined: no misses register; mismatches have no effect beyond being ignored.

Test Plan:
- All tests use CLKS_PER_SEC=4, GAME_SECONDS=3, NUM_PAIRS=2, SCORE_HIT=10.
- Reset: assert userquit mid-RUN with secs_left=2 → outputs return to secs_left=3, pairs_left=2, score=0, gameOver=0 immediately, without waiting for a clock edge.
- Win: ingameOn=1, two matched pulses 3 cycles apart → pairs_left 2→1→0, score 10→20, gameOver=win=1 on the edge after the second pulse. Holds after ingameOn=0.
- Timeout: ingameOn=1, no pulses → sec_tick every 4 cycles, secs_left 3→2→1→0, gameOver=1 and win=0 at the 12th cycle of RUN. Holds until userquit.
- Tie: one match early, then the second match coincident with the third tick → WON, win=1, secs_left=0.
- Abort and ignore: ingameOn drops in RUN with pairs_left=1 → IDLE, counters reloaded, gameOver=0. A pair_valid pulse while in IDLE → no change.
- MISS_LIMIT_EN with MAX_MISSES=2: two mismatch pulses → gameOver=1, win=0, score=0.

Source files
------------

// File: rtl/match_timer_judge.sv
// match_timer_judge: round judge for the memory-tile game.
// It counts down the round timer and the unmatched pairs while the game runs.
// It raises gameOver (and win) when all pairs are matched or when time runs out.
// gameOver holds until userquit resets the block.
// Optional feature: define MISS_LIMIT_EN to add a mismatch counter.
// With it, the round is lost on the MAX_MISSES-th mismatch.
module match_timer_judge #(
  parameter int CLKS_PER_SEC = 50000000,
  parameter int GAME_SECONDS = 60,
  parameter int NUM_PAIRS    = 8,
  parameter int SCORE_HIT    = 10,
  parameter int MAX_MISSES   = 5
) (
  input  logic       CLOCK_50,
  input  logic       userquit,
  input  logic       ingameOn,
  input  logic       pair_valid,
  input  logic       pair_match,
  output logic       gameOver,
  output logic       win,
  output logic [6:0] secs_left,
  output logic [4:0] pairs_left,
  output logic [7:0] score,
  output logic       sec_tick
);

  localparam int              PW         = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
  localparam logic [PW-1:0]   PRESC_MAX  = PW'(CLKS_PER_SEC - 1);
  localparam logic [PW-1:0]   PRESC_ONE  = PW'(1);
  localparam logic [6:0]      SECS_INIT  = 7'(GAME_SECONDS);
  localparam logic [4:0]      PAIRS_INIT = 5'(NUM_PAIRS);
  localparam logic [8:0]      HIT9       = 9'(SCORE_HIT);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WON, S_LOST} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [PW-1:0] r_presc;
  logic [6:0]    r_secs;
  logic [4:0]    r_pairs;
  logic [7:0]    r_score;
  logic          r_game_over;
  logic          r_win;

  logic w_run;
  logic w_wrap;
  logic w_hit;
  logic w_win_evt;
  logic w_loss_evt;
  logic w_abort;

  // Score accumulation saturates at 255 rather than wrapping.
  function automatic logic [7:0] sat_add_score(input logic [7:0] a);
    logic [8:0] s;
    s = {1'b0, a} + HIT9;
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  assign w_run     = (r_state == S_RUN);
  assign w_wrap    = w_run && (r_presc == PRESC_MAX);
  assign w_hit     = w_run && pair_valid && pair_match;
  // Winning beats any same-cycle loss condition.
  assign w_win_evt = w_hit && (r_pairs == 5'd1);

`ifdef MISS_LIMIT_EN
  logic [2:0] r_misses;
  logic [2:0] w_misses_inc;
  logic       w_miss;
  logic       w_miss_loss;

  assign w_miss       = w_run && pair_valid && !pair_match;
  assign w_misses_inc = (r_misses == 3'd7) ? 3'd7 : r_misses + 3'd1;
  assign w_miss_loss  = w_miss && (r_misses != 3'd7) && (int'(w_misses_inc) == MAX_MISSES);
  assign w_loss_evt   = !w_win_evt && ((w_wrap && (r_secs == 7'd1)) || w_miss_loss);
`else
  assign w_loss_evt   = !w_win_evt && w_wrap && (r_secs == 7'd1);
`endif

  // Leaving the game without a verdict aborts the round.
  assign w_abort = w_run && !ingameOn && !w_win_evt && !w_loss_evt;

  // State register.
  always_ff @(posedge CLOCK_50 or posedge userquit) begin
    if (userquit) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic; WON and LOST are left only through userquit.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (ingameOn) w_next = S_RUN;
      S_RUN: begin
        if (w_win_evt)       w_next = S_WON;
        else if (w_loss_evt) w_next = S_LOST;
        else if (w_abort)    w_next = S_IDLE;
      end
      default: w_next = r_state;
    endcase
  end

  // Counters and registered verdict outputs.
  // In IDLE and on abort, the counters are reloaded; in WON/LOST they freeze.
  always_ff @(posedge CLOCK_50 or posedge userquit) begin
    if (userquit) begin
      r_presc     <= '0;
      r_secs      <= SECS_INIT;
      r_pairs     <= PAIRS_INIT;
      r_score     <= 8'd0;
      r_game_over <= 1'b0;
      r_win       <= 1'b0;
`ifdef MISS_LIMIT_EN
      r_misses    <= 3'd0;
`endif
    end else begin
      r_game_over <= (w_next == S_WON) || (w_next == S_LOST);
      r_win       <= (w_next == S_WON);
      if ((r_state == S_IDLE) || w_abort) begin
        r_presc  <= '0;
        r_secs   <= SECS_INIT;
        r_pairs  <= PAIRS_INIT;
        r_score  <= 8'd0;
`ifdef MISS_LIMIT_EN
        r_misses <= 3'd0;
`endif
      end else if (w_run) begin
        r_presc <= w_wrap ? '0 : r_presc + PRESC_ONE;
        if (w_wrap && (r_secs != 7'd0)) r_secs <= r_secs - 7'd1;
        if (w_hit && (r_pairs != 5'd0)) begin
          r_pairs <= r_pairs - 5'd1;
          r_score <= sat_add_score(r_score);
        end
`ifdef MISS_LIMIT_EN
        if (w_miss) r_misses <= w_misses_inc;
`endif
      end
    end
  end

  assign gameOver   = r_game_over;
  assign win        = r_win;
  assign secs_left  = r_secs;
  assign pairs_left = r_pairs;
  assign score      = r_score;
  // The pulse marks the last prescaler cycle of each running second.
  // It is decoded from registers only.
  assign sec_tick   = w_wrap;

endmodule

// File: tb/tb_match_timer_judge.sv
// Testbench for match_timer_judge (CLKS_PER_SEC=4, GAME_SECONDS=3, NUM_PAIRS=2).
module tb_match_timer_judge;

  logic       clk = 1'b0;
  logic       userquit;
  logic       ingameOn;
  logic       pair_valid;
  logic       pair_match;
  logic       gameOver;
  logic       win;
  logic [6:0] secs_left;
  logic [4:0] pairs_left;
  logic [7:0] score;
  logic       sec_tick;

  int n_checks = 0;
  int n_fail   = 0;

  match_timer_judge #(
    .CLKS_PER_SEC(4),
    .GAME_SECONDS(3),
    .NUM_PAIRS(2),
    .SCORE_HIT(10),
    .MAX_MISSES(2)
  ) dut (
    .CLOCK_50(clk),
    .userquit(userquit),
    .ingameOn(ingameOn),
    .pair_valid(pair_valid),
    .pair_match(pair_match),
    .gameOver(gameOver),
    .win(win),
    .secs_left(secs_left),
    .pairs_left(pairs_left),
    .score(score),
    .sec_tick(sec_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ig; int pv; int pm;
    int go; int w; int secs; int pairs; int score; int tk;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int go, input int w, input int secs,
                           input int pairs, input int sc, input int tk);
    check({tag, ".gameOver"},   int'(gameOver),   go);
    check({tag, ".win"},        int'(win),        w);
    check({tag, ".secs_left"},  int'(secs_left),  secs);
    check({tag, ".pairs_left"}, int'(pairs_left), pairs);
    check({tag, ".score"},      int'(score),      sc);
    check({tag, ".sec_tick"},   int'(sec_tick),   tk);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    userquit   = 1'b1;
    ingameOn   = 1'b0;
    pair_valid = 1'b0;
    pair_match = 1'b0;
    step();
    step();
    userquit = 1'b0;
  endtask

  initial begin
    // Win sequence: each row is the inputs for one edge and the outputs after it.
    tbl[0] = '{1, 0, 0,  0, 0, 3, 2,  0, 0};
    tbl[1] = '{1, 1, 1,  0, 0, 3, 1, 10, 0};
    tbl[2] = '{1, 0, 0,  0, 0, 3, 1, 10, 0};
    tbl[3] = '{1, 0, 0,  0, 0, 3, 1, 10, 1};
    tbl[4] = '{1, 1, 1,  1, 1, 2, 0, 20, 0};
    tbl[5] = '{0, 0, 0,  1, 1, 2, 0, 20, 0};
    tbl[6] = '{0, 1, 1,  1, 1, 2, 0, 20, 0};

    // Reset state
    do_reset();
    check_all("reset", 0, 0, 3, 2, 0, 0);

    // Win, then hold after ingameOn drops
    for (int i = 0; i < 7; i++) begin
      ingameOn   = (tbl[i].ig != 0);
      pair_valid = (tbl[i].pv != 0);
      pair_match = (tbl[i].pm != 0);
      step();
      check_all($sformatf("win_v%0d", i), tbl[i].go, tbl[i].w, tbl[i].secs,
                tbl[i].pairs, tbl[i].score, tbl[i].tk);
    end
    pair_valid = 1'b0;

    // Timeout: tick every 4 cycles, lost after the 12th RUN cycle
    do_reset();
    ingameOn = 1'b1;
    step();
    for (int k = 1; k <= 12; k++) begin
      check(  $sformatf("to_c%0d.secs_left", k), int'(secs_left), 3 - (k - 1) / 4);
      check(  $sformatf("to_c%0d.sec_tick", k),  int'(sec_tick),  (k % 4 == 0) ? 1 : 0);
      check(  $sformatf("to_c%0d.gameOver", k),  int'(gameOver),  0);
      step();
    end
    check_all("timeout_end", 1, 0, 0, 2, 0, 0);
    ingameOn = 1'b0;
    step();
    step();
    check_all("timeout_hold", 1, 0, 0, 2, 0, 0);
    userquit = 1'b1;
    #1;
    check_all("timeout_quit", 0, 0, 3, 2, 0, 0);
    step();
    userquit = 1'b0;

    // Asynchronous reset mid-RUN with secs_left=2
    do_reset();
    ingameOn = 1'b1;
    step();
    pair_valid = 1'b1; pair_match = 1'b1;
    step();
    pair_valid = 1'b0; pair_match = 1'b0;
    step(); step(); step();
    check_all("async_pre", 0, 0, 2, 1, 10, 0);
    #3;
    userquit = 1'b1;
    #1;
    check_all("async_rst", 0, 0, 3, 2, 0, 0);
    ingameOn = 1'b0;
    step();
    userquit = 1'b0;

    // Tie: last match lands on the final tick
    do_reset();
    ingameOn = 1'b1;
    step();
    pair_valid = 1'b1; pair_match = 1'b1;
    step();
    pair_valid = 1'b0; pair_match = 1'b0;
    for (int k = 0; k < 10; k++) step();
    check_all("tie_pre", 0, 0, 1, 1, 10, 1);
    pair_valid = 1'b1; pair_match = 1'b1;
    step();
    pair_valid = 1'b0; pair_match = 1'b0;
    check_all("tie_won", 1, 1, 0, 0, 20, 0);

    // Abort with one pair left, then an ignored pulse in IDLE
    do_reset();
    ingameOn = 1'b1;
    step();
    pair_valid = 1'b1; pair_match = 1'b1;
    step();
    pair_valid = 1'b0; pair_match = 1'b0;
    check_all("abort_pre", 0, 0, 3, 1, 10, 0);
    ingameOn = 1'b0;
    step();
    check_all("abort_idle", 0, 0, 3, 2, 0, 0);
    pair_valid = 1'b1; pair_match = 1'b1;
    step();
    pair_valid = 1'b0; pair_match = 1'b0;
    step();
    check_all("idle_ignore", 0, 0, 3, 2, 0, 0);

    // Two mismatches
    do_reset();
    ingameOn = 1'b1;
    step();
    pair_valid = 1'b1; pair_match = 1'b0;
    step();
    step();
    pair_valid = 1'b0;
`ifdef MISS_LIMIT_EN
    check_all("miss_limit", 1, 0, 3, 2, 0, 0);
`else
    check_all("miss_ignore", 0, 0, 3, 2, 0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
